// File: rtl/framebuffer_writer_pkg.sv
// Shared frame buffer constants and writer state encoding.
// Also consumed by the scan-out address counter.
package framebuffer_writer_pkg;

    localparam int DEF_IMG_W  = 64;
    localparam int DEF_IMG_H  = 64;
    localparam int DEF_ADDR_W = 12;
    localparam int PIXELS     = DEF_IMG_W * DEF_IMG_H;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } fbw_state_e;

endpackage

// File: rtl/framebuffer_writer.sv
// Framed, flow-controlled raster writer into the frame buffer RAM.
// Optional macro VBLANK_SYNC_EN: accept pixels only during vblank.
module framebuffer_writer
    import framebuffer_writer_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_pixel,
    input  logic              s_sof,
    input  logic              vblank,
    output logic [ADDR_W-1:0] wraddress,
    output logic              data,
    output logic              wren,
    output logic              busy,
    output logic              frame_done,
    output logic              sof_restart
);

    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    fbw_state_e        state_q;
    fbw_state_e        state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic              wr_fire;
    logic              done_d;
    logic              restart_d;
    logic              gate;
    logic              accept;

`ifdef VBLANK_SYNC_EN
    assign gate = vblank;
`else
    assign gate = 1'b1 | vblank;
`endif

    assign s_ready = reset_n & gate;
    assign accept  = s_valid & s_ready;
    assign busy    = (state_q == ST_WRITE);

    // Next state, pixel index and the write to issue for this cycle's beat
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_addr_d = idx_q;
        wr_fire   = 1'b0;
        done_d    = 1'b0;
        restart_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && s_sof) begin
                    wr_fire   = 1'b1;
                    wr_addr_d = '0;
                    idx_d     = IDX_ONE;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    wr_fire = 1'b1;
                    if (s_sof) begin
                        wr_addr_d = '0;
                        idx_d     = IDX_ONE;
                        restart_d = 1'b1;
                    end else if (idx_q == PIX_LAST) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State and pixel index registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Registered RAM write port; address and data hold while wren is low
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wren        <= 1'b0;
            wraddress   <= '0;
            data        <= 1'b0;
            frame_done  <= 1'b0;
            sof_restart <= 1'b0;
        end else begin
            wren        <= wr_fire;
            frame_done  <= done_d;
            sof_restart <= restart_d;
            if (wr_fire) begin
                wraddress <= wr_addr_d;
                data      <= s_pixel;
            end
        end
    end

endmodule
